// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch queue: entry layout and size defaults.
package fetch_queue_pkg;

  localparam int FQ_DATA_WIDTH = 32;
  localparam int FQ_DEPTH      = 4;

  typedef struct packed {
    logic [FQ_DATA_WIDTH-1:0] pc;
    logic [FQ_DATA_WIDTH-1:0] instruction;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one
// combinational read port, whole array cleared on reset.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fq_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fq_entry_t rd_data
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: no fall-through, no
// bypass when full, flush discards everything including the offered entry.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  // Must equal FQ_DATA_WIDTH, since entries are stored as fq_entry_t.
  parameter int DATA_WIDTH = FQ_DATA_WIDTH,
  parameter int DEPTH      = FQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_Flush,
  input  logic                    i_Valid,
  input  logic [DATA_WIDTH-1:0]   i_PC,
  input  logic [DATA_WIDTH-1:0]   i_Instruction,
  output logic                    o_Ready,
  output logic                    o_Valid,
  output logic [DATA_WIDTH-1:0]   o_PC,
  output logic [DATA_WIDTH-1:0]   o_Instruction,
  input  logic                    i_Ready,
  output logic [$clog2(DEPTH):0]  o_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;

  assign o_Ready = (count < FULL_COUNT) && !i_Flush;
  assign o_Valid = (count != '0) && !i_Flush;
  assign push    = i_Valid && o_Ready;
  assign pop     = o_Valid && i_Ready;

  assign wr_entry.pc          = i_PC;
  assign wr_entry.instruction = i_Instruction;

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset || i_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields are forced to zero whenever nothing is presented to decode.
  assign o_PC          = o_Valid ? rd_entry.pc          : '0;
  assign o_Instruction = o_Valid ? rd_entry.instruction : '0;
  assign o_Count       = count;

endmodule
